// File: rtl/eth_csr_pkg.sv
// Shared types and constants for the E10 CSR bus arbiter.
// Optional feature macro: CSR_TIMEOUT_EN (waitrequest watchdog).
package eth_csr_pkg;

    localparam int          CSR_ADDR_W       = 16;
    localparam int          CSR_DATA_W       = 32;
    localparam logic [31:0] CSR_TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } csr_state_t;

endpackage

// File: rtl/eth_csr_rr_arb.sv
// Two-way round-robin pick. When both masters request, the one that was not
// granted last wins; a lone requester always wins. Purely combinational.
module eth_csr_rr_arb (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       pick,
    output logic [1:0] pick_oh
);

    // Select the winner index and its one-hot form (all zero with no request)
    always_comb begin
        pick    = 1'b0;
        pick_oh = 2'b00;
        if (req == 2'b11) begin
            pick = ~last_grant;
        end else if (req[1]) begin
            pick = 1'b1;
        end
        if (|req) begin
            pick_oh = pick ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/eth_csr_arbiter.sv
// Two-master Avalon-MM arbiter in front of the E10 CSR address decoder.
// Port 0 is host MMIO, port 1 the init/stats-poll sequencer. One access is
// forwarded at a time; slave-side signals are registered, and the response is
// steered combinationally back to the granted master only.
// Optional feature macro: CSR_TIMEOUT_EN adds a watchdog that force-completes
// an access stuck on waitrequest, returning CSR_TIMEOUT_DATA.
module eth_csr_arbiter
    import eth_csr_pkg::*;
#(
    parameter int ADDR_W         = CSR_ADDR_W,
    parameter int DATA_W         = CSR_DATA_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_csr_clk,
    input  logic              csr_reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_waitrequest,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_waitrequest,

    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_waitrequest,

    output logic              timeout_pulse
);

    csr_state_t  state;
    logic        grant;
    logic        last_grant;
    logic        pick;
    logic [1:0]  pick_oh;
    logic        win_m1;
    logic        win_rd;
    logic        win_wr;
    logic        busy;
    logic        timeout_hit;
    logic        done;
    logic [DATA_W-1:0] rsp_data;

    eth_csr_rr_arb u_rr_arb (
        .req        ({m1_read | m1_write, m0_read | m0_write}),
        .last_grant (last_grant),
        .pick       (pick),
        .pick_oh    (pick_oh)
    );

    // Command of the winning master; write takes precedence over read
    assign win_m1 = pick_oh[1];
    assign win_wr = win_m1 ? m1_write : m0_write;
    assign win_rd = (win_m1 ? m1_read : m0_read) & ~win_wr;

    assign busy = (state == BUSY);

`ifdef CSR_TIMEOUT_EN
    logic [15:0] wdog;

    // Watchdog: zero while idle, so it starts each access from 0, and counts stalled BUSY cycles
    always_ff @(posedge clk_csr_clk or negedge csr_reset_n) begin
        if (!csr_reset_n) begin
            wdog <= '0;
        end else if (!busy) begin
            wdog <= '0;
        end else if (s_waitrequest) begin
            wdog <= wdog + 16'd1;
        end
    end

    assign timeout_hit = busy && s_waitrequest && (wdog == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign timeout_pulse = timeout_hit;
    assign done          = busy && (!s_waitrequest || timeout_hit);
    assign rsp_data      = timeout_hit ? DATA_W'(CSR_TIMEOUT_DATA) : s_readdata;

    // Response steering: only the granted master ever sees waitrequest low or non-zero data
    always_comb begin
        m0_waitrequest = ~(done && !grant);
        m1_waitrequest = ~(done && grant);
        m0_readdata    = (busy && !grant) ? rsp_data : '0;
        m1_readdata    = (busy &&  grant) ? rsp_data : '0;
    end

    // Arbitration FSM: grant and launch from IDLE, hold slave signals until completion
    // NOTE: every register here uses <= so all of them update from the same pre-edge values.
    always_ff @(posedge clk_csr_clk or negedge csr_reset_n) begin
        if (!csr_reset_n) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            s_address   <= '0;
            s_read      <= 1'b0;
            s_write     <= 1'b0;
            s_writedata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pick_oh) begin
                        state       <= BUSY;
                        grant       <= pick;
                        last_grant  <= pick;
                        s_address   <= win_m1 ? m1_address   : m0_address;
                        s_writedata <= win_m1 ? m1_writedata : m0_writedata;
                        s_read      <= win_rd;
                        s_write     <= win_wr;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state   <= IDLE;
                        s_read  <= 1'b0;
                        s_write <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_csr_arbiter.sv
// Self-checking bench for eth_csr_arbiter: a table of single-master accesses
// plus hand-written sequences for arbitration, back-to-back alternation,
// reset during an access and the waitrequest watchdog (CSR_TIMEOUT_EN).
module tb_eth_csr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [15:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [15:0] s_address;
    logic        s_read, s_write;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic        s_waitrequest;
    logic        timeout_pulse;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        port;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          wait_cycles;
        logic [31:0] rdata;
        logic        exp_s_read;
        logic        exp_s_write;
    } vec_t;

    vec_t vecs[6];

    eth_csr_arbiter #(
        .ADDR_W         (16),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_csr_clk    (clk),
        .csr_reset_n    (rst_n),
        .m0_address     (m0_address),
        .m0_read        (m0_read),
        .m0_write       (m0_write),
        .m0_writedata   (m0_writedata),
        .m0_readdata    (m0_readdata),
        .m0_waitrequest (m0_waitrequest),
        .m1_address     (m1_address),
        .m1_read        (m1_read),
        .m1_write       (m1_write),
        .m1_writedata   (m1_writedata),
        .m1_readdata    (m1_readdata),
        .m1_waitrequest (m1_waitrequest),
        .s_address      (s_address),
        .s_read         (s_read),
        .s_write        (s_write),
        .s_writedata    (s_writedata),
        .s_readdata     (s_readdata),
        .s_waitrequest  (s_waitrequest),
        .timeout_pulse  (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic wait_of(input logic p);
        return p ? m1_waitrequest : m0_waitrequest;
    endfunction

    function automatic logic [31:0] rdata_of(input logic p);
        return p ? m1_readdata : m0_readdata;
    endfunction

    task automatic set_req(input logic p, input logic rd, input logic wr,
                           input logic [15:0] addr, input logic [31:0] wdata);
        if (p) begin
            m1_read = rd; m1_write = wr; m1_address = addr; m1_writedata = wdata;
        end else begin
            m0_read = rd; m0_write = wr; m0_address = addr; m0_writedata = wdata;
        end
    endtask

    // One complete access from IDLE by a single master, checked cycle by cycle
    task automatic run_txn(input vec_t v, input string tag);
        set_req(v.port, v.rd, v.wr, v.addr, v.wdata);
        s_waitrequest = 1'b1;
        s_readdata    = v.rdata;
        #1;
        check({tag, " idle_wait"}, 32'(wait_of(v.port)), 32'd1);
        step();
        check({tag, " s_read"},      32'(s_read),  32'(v.exp_s_read));
        check({tag, " s_write"},     32'(s_write), 32'(v.exp_s_write));
        check({tag, " s_address"},   32'(s_address), 32'(v.addr));
        check({tag, " s_writedata"}, s_writedata, v.wdata);
        for (int c = 0; c < v.wait_cycles; c++) begin
            check({tag, " stall_wait"}, 32'(wait_of(v.port)), 32'd1);
            step();
        end
        s_waitrequest = 1'b0;
        #1;
        check({tag, " done_wait"},   32'(wait_of(v.port)), 32'd0);
        check({tag, " done_rdata"},  rdata_of(v.port), v.rdata);
        check({tag, " other_wait"},  32'(wait_of(!v.port)), 32'd1);
        check({tag, " other_rdata"}, rdata_of(!v.port), 32'd0);
        step();
        set_req(v.port, 1'b0, 1'b0, 16'h0, 32'h0);
        s_waitrequest = 1'b1;
        #1;
        check({tag, " after_wait"},  32'(wait_of(v.port)), 32'd1);
        check({tag, " after_cmd"},   32'({s_read, s_write}), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        vec_t v;
        int   n;
        logic exp_p;
        logic [15:0] exp_addr;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0400, 32'h0000_0000, 3, 32'h1234_5678, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h0800, 32'hA5A5_0001, 0, 32'h0BAD_F00D, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h0010, 32'h0000_0000, 1, 32'hCAFE_0010, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 16'h0100, 32'h0000_0100, 0, 32'h0000_0000, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 16'hFFFF, 32'hFFFF_FFFF, 2, 32'h5555_AAAA, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 32'h0000_0000, 0, 32'h8000_0001, 1'b1, 1'b0};

        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
        s_readdata    = 32'h7777_7777;
        s_waitrequest = 1'b1;
        #3;

        // Reset values
        check("rst s_read",        32'(s_read), 32'd0);
        check("rst s_write",       32'(s_write), 32'd0);
        check("rst s_address",     32'(s_address), 32'd0);
        check("rst s_writedata",   s_writedata, 32'd0);
        check("rst m0_wait",       32'(m0_waitrequest), 32'd1);
        check("rst m1_wait",       32'(m1_waitrequest), 32'd1);
        check("rst m0_rdata",      m0_readdata, 32'd0);
        check("rst m1_rdata",      m1_readdata, 32'd0);
        check("rst timeout_pulse", 32'(timeout_pulse), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Table of single-master accesses (T1 is vecs[0], T6 is vecs[3])
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // T2: simultaneous requests right after reset, m0 wins first
        do_reset();
        set_req(1'b0, 1'b0, 1'b1, 16'h2000, 32'h1111_2222);
        set_req(1'b1, 1'b1, 1'b0, 16'h0010, 32'h0);
        step();
        check("t2 first addr",   32'(s_address), 32'h2000);
        check("t2 first write",  32'(s_write), 32'd1);
        check("t2 m1 held",      32'(m1_waitrequest), 32'd1);
        s_waitrequest = 1'b0;
        #1;
        check("t2 m0 done",      32'(m0_waitrequest), 32'd0);
        step();
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        s_waitrequest = 1'b1;
        #1;
        check("t2 idle cmd",     32'({s_read, s_write}), 32'd0);
        check("t2 idle m1 wait", 32'(m1_waitrequest), 32'd1);
        step();
        check("t2 second addr",  32'(s_address), 32'h0010);
        check("t2 second read",  32'(s_read), 32'd1);
        s_readdata    = 32'h0000_ABCD;
        s_waitrequest = 1'b0;
        #1;
        check("t2 m1 done",      32'(m1_waitrequest), 32'd0);
        check("t2 m1 rdata",     m1_readdata, 32'h0000_ABCD);
        step();
        set_req(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
        s_waitrequest = 1'b1;

        // T3: 8 back-to-back reads per master, grants alternate starting at m0
        set_req(1'b0, 1'b1, 1'b0, 16'h1000, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 16'h3000, 32'h0);
        #1;
        for (int k = 0; k < 16; k++) begin
            exp_p    = (k % 2) == 1;
            exp_addr = (exp_p ? 16'h3000 : 16'h1000) + 16'(k / 2);
            check($sformatf("t3.%0d idle wait", k), 32'({m0_waitrequest, m1_waitrequest}), 32'd3);
            check($sformatf("t3.%0d idle read", k), 32'(s_read), 32'd0);
            step();
            check($sformatf("t3.%0d read", k), 32'(s_read), 32'd1);
            check($sformatf("t3.%0d addr", k), 32'(s_address), 32'(exp_addr));
            s_readdata    = 32'hB000_0000 + 32'(k);
            s_waitrequest = 1'b0;
            #1;
            check($sformatf("t3.%0d grant wait", k), 32'(wait_of(exp_p)), 32'd0);
            check($sformatf("t3.%0d rdata", k), rdata_of(exp_p), 32'hB000_0000 + 32'(k));
            check($sformatf("t3.%0d other wait", k), 32'(wait_of(!exp_p)), 32'd1);
            step();
            s_waitrequest = 1'b1;
            n = k / 2 + 1;
            if (n < 8) begin
                set_req(exp_p, 1'b1, 1'b0, (exp_p ? 16'h3000 : 16'h1000) + 16'(n), 32'h0);
            end else begin
                set_req(exp_p, 1'b0, 1'b0, 16'h0, 32'h0);
            end
            #1;
        end
        step();
        check("t3 drained", 32'({s_read, s_write}), 32'd0);

        // T4: reset in the middle of a BUSY access
        set_req(1'b0, 1'b1, 1'b0, 16'h0400, 32'h0);
        step();
        check("t4 busy read", 32'(s_read), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4 rst s_read",  32'(s_read), 32'd0);
        check("t4 rst s_addr",  32'(s_address), 32'd0);
        check("t4 rst waits",   32'({m0_waitrequest, m1_waitrequest}), 32'd3);
        s_waitrequest = 1'b0;
        s_readdata    = 32'h4444_4444;
        #1;
        check("t4 no completion", 32'(m0_waitrequest), 32'd1);
        check("t4 rst m0_rdata",  m0_readdata, 32'd0);
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        s_waitrequest = 1'b1;
        step();
        v = '{1'b1, 1'b1, 1'b0, 16'h0055, 32'h0, 1, 32'h5500_0055, 1'b1, 1'b0};
        run_txn(v, "t4 m1");

`ifdef CSR_TIMEOUT_EN
        // T5: stuck waitrequest is force-completed on BUSY cycle 16
        set_req(1'b0, 1'b1, 1'b0, 16'h0200, 32'h0);
        s_waitrequest = 1'b1;
        step();
        for (int c = 1; c < 16; c++) begin
            check($sformatf("t5 c%0d wait", c),  32'(m0_waitrequest), 32'd1);
            check($sformatf("t5 c%0d pulse", c), 32'(timeout_pulse), 32'd0);
            step();
        end
        check("t5 wait",   32'(m0_waitrequest), 32'd0);
        check("t5 rdata",  m0_readdata, 32'hDEAD_BEEF);
        check("t5 pulse",  32'(timeout_pulse), 32'd1);
        check("t5 m1",     32'(m1_waitrequest), 32'd1);
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        step();
        check("t5 idle read",  32'(s_read), 32'd0);
        check("t5 pulse off",  32'(timeout_pulse), 32'd0);
        check("t5 idle wait",  32'(m0_waitrequest), 32'd1);
`else
        // Without the watchdog a long stall never completes on its own
        set_req(1'b0, 1'b1, 1'b0, 16'h0200, 32'h0);
        s_waitrequest = 1'b1;
        step();
        for (int c = 1; c <= 40; c++) begin
            check($sformatf("stall c%0d wait", c),  32'(m0_waitrequest), 32'd1);
            check($sformatf("stall c%0d pulse", c), 32'(timeout_pulse), 32'd0);
            step();
        end
        check("stall still read", 32'(s_read), 32'd1);
        s_readdata    = 32'h0000_0200;
        s_waitrequest = 1'b0;
        #1;
        check("stall done wait",  32'(m0_waitrequest), 32'd0);
        check("stall done rdata", m0_readdata, 32'h0000_0200);
        step();
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        s_waitrequest = 1'b1;
        #1;
        check("stall idle read",  32'(s_read), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the bench cannot hang
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, limit 500000 reached");
        $fatal(1);
    end

endmodule
